// File: rtl/axi_dma_cmd_queue_if.sv
// Command/status handshake bundle between a control master and axi_dma_cmd_queue.
// slave = queue side (accepts commands, sources status); master = control side.
interface axi_dma_cmd_queue_if #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_TAG_WIDTH      = 4
) ();
  logic                        s_cmd_valid;
  logic                        s_cmd_ready;
  logic                        s_cmd_opcode;
  logic [C_AXI_ADDR_WIDTH-1:0] s_cmd_addr;
  logic [15:0]                 s_cmd_bytes;
  logic [C_TAG_WIDTH-1:0]      s_cmd_tag;

  logic                        m_sts_valid;
  logic                        m_sts_ready;
  logic [C_TAG_WIDTH-1:0]      m_sts_tag;
  logic                        m_sts_opcode;
  logic [1:0]                  m_sts_resp;
  logic                        m_sts_timeout;

  modport slave (
    input  s_cmd_valid, s_cmd_opcode, s_cmd_addr, s_cmd_bytes, s_cmd_tag,
    output s_cmd_ready,
    output m_sts_valid, m_sts_tag, m_sts_opcode, m_sts_resp, m_sts_timeout,
    input  m_sts_ready
  );

  modport master (
    output s_cmd_valid, s_cmd_opcode, s_cmd_addr, s_cmd_bytes, s_cmd_tag,
    input  s_cmd_ready,
    input  m_sts_valid, m_sts_tag, m_sts_opcode, m_sts_resp, m_sts_timeout,
    output m_sts_ready
  );
endinterface

// File: rtl/axi_dma_cmd_queue.sv
// FIFO-buffered, one-in-flight DMA command issuer: accept->trigger 2 cycles, busy fall->status 1 cycle; s_cmd_ready low when
// the FIFO is full, status held until m_sts_ready. Optional start timeout enabled by AXI_DMA_CMD_QUEUE_TIMEOUT_EN.
module axi_dma_cmd_queue #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_QUEUE_DEPTH    = 8,
  parameter int unsigned C_TAG_WIDTH      = 4,
  parameter int unsigned C_START_TIMEOUT  = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  axi_dma_cmd_queue_if.slave                ctrl,
  output logic                              dma_trigger,
  output logic                              dma_opcode,
  output logic [C_AXI_ADDR_WIDTH-1:0]       dma_start_addr,
  output logic [15:0]                       dma_num_bytes,
  input  logic                              dma_busy,
  input  logic [3:0]                        dma_response,
  output logic [$clog2(C_QUEUE_DEPTH):0]    queue_level,
  output logic                              idle
);

  localparam int unsigned PW = $clog2(C_QUEUE_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;
  localparam lvl_t FULL = lvl_t'(C_QUEUE_DEPTH);

  typedef struct packed {
    logic                        opcode;
    logic [C_AXI_ADDR_WIDTH-1:0] addr;
    logic [15:0]                 bytes;
    logic [C_TAG_WIDTH-1:0]      tag;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_WAIT_DONE, S_REPORT} state_t;

  cmd_t   mem_q [C_QUEUE_DEPTH];
  cmd_t   wdat, head;
  ptr_t   wr_ptr_q, rd_ptr_q;
  lvl_t   level_q, level_d;
  logic   push, pop;

  state_t                        state_q, state_d;
  logic                          trig_q, trig_d;
  logic                          dma_op_q, dma_op_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   dma_addr_q, dma_addr_d;
  logic [15:0]                   dma_bytes_q, dma_bytes_d;
  logic [C_TAG_WIDTH-1:0]        cur_tag_q, cur_tag_d;
  logic                          cur_op_q, cur_op_d;
  logic                          sts_vld_q, sts_vld_d;
  logic [C_TAG_WIDTH-1:0]        sts_tag_q, sts_tag_d;
  logic                          sts_op_q, sts_op_d;
  logic [1:0]                    sts_resp_q, sts_resp_d;

`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(C_START_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sts_to_q, sts_to_d;
`endif

  // Ready comes from the registered level, so a full queue refuses a push even on a pop cycle.
  assign ctrl.s_cmd_ready = ~rst & (level_q != FULL);
  assign push = ctrl.s_cmd_valid & ctrl.s_cmd_ready;
  assign wdat = '{opcode: ctrl.s_cmd_opcode, addr: ctrl.s_cmd_addr,
                  bytes: ctrl.s_cmd_bytes, tag: ctrl.s_cmd_tag};
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdat;
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + lvl_t'(1);
    else if (pop && !push) level_d = level_q - lvl_t'(1);
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    trig_d      = 1'b0;
    dma_op_d    = dma_op_q;
    dma_addr_d  = dma_addr_q;
    dma_bytes_d = dma_bytes_q;
    cur_tag_d   = cur_tag_q;
    cur_op_d    = cur_op_q;
    sts_vld_d   = sts_vld_q;
    sts_tag_d   = sts_tag_q;
    sts_op_d    = sts_op_q;
    sts_resp_d  = sts_resp_q;
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
    cnt_d       = cnt_q;
    sts_to_d    = sts_to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !dma_busy) begin
          pop       = 1'b1;
          cur_tag_d = head.tag;
          cur_op_d  = head.opcode;
          if (head.bytes == '0) begin
            // Zero-length commands never reach the engine; report success directly.
            sts_vld_d  = 1'b1;
            sts_tag_d  = head.tag;
            sts_op_d   = head.opcode;
            sts_resp_d = 2'b00;
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
            sts_to_d   = 1'b0;
`endif
            state_d    = S_REPORT;
          end else begin
            trig_d      = 1'b1;
            dma_op_d    = head.opcode;
            dma_addr_d  = head.addr;
            dma_bytes_d = head.bytes;
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
            cnt_d       = '0;
`endif
            state_d     = S_WAIT_START;
          end
        end
      end
      S_WAIT_START: begin
        if (dma_busy) begin
          state_d = S_WAIT_DONE;
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
        end else if (cnt_q == CW'(C_START_TIMEOUT - 1)) begin
          sts_vld_d  = 1'b1;
          sts_tag_d  = cur_tag_q;
          sts_op_d   = cur_op_q;
          sts_resp_d = 2'b10;
          sts_to_d   = 1'b1;
          state_d    = S_REPORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      S_WAIT_DONE: begin
        if (!dma_busy) begin
          sts_vld_d  = 1'b1;
          sts_tag_d  = cur_tag_q;
          sts_op_d   = cur_op_q;
          sts_resp_d = cur_op_q ? dma_response[3:2] : dma_response[1:0];
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
          sts_to_d   = 1'b0;
`endif
          state_d    = S_REPORT;
        end
      end
      S_REPORT: begin
        if (ctrl.m_sts_ready) begin
          sts_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      dma_op_q    <= 1'b0;
      dma_addr_q  <= '0;
      dma_bytes_q <= '0;
      cur_tag_q   <= '0;
      cur_op_q    <= 1'b0;
      sts_vld_q   <= 1'b0;
      sts_tag_q   <= '0;
      sts_op_q    <= 1'b0;
      sts_resp_q  <= '0;
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
      cnt_q       <= '0;
      sts_to_q    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      level_q     <= level_d;
      state_q     <= state_d;
      trig_q      <= trig_d;
      dma_op_q    <= dma_op_d;
      dma_addr_q  <= dma_addr_d;
      dma_bytes_q <= dma_bytes_d;
      cur_tag_q   <= cur_tag_d;
      cur_op_q    <= cur_op_d;
      sts_vld_q   <= sts_vld_d;
      sts_tag_q   <= sts_tag_d;
      sts_op_q    <= sts_op_d;
      sts_resp_q  <= sts_resp_d;
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
      cnt_q       <= cnt_d;
      sts_to_q    <= sts_to_d;
`endif
    end
  end

  assign ctrl.m_sts_valid  = sts_vld_q;
  assign ctrl.m_sts_tag    = sts_tag_q;
  assign ctrl.m_sts_opcode = sts_op_q;
  assign ctrl.m_sts_resp   = sts_resp_q;
`ifdef AXI_DMA_CMD_QUEUE_TIMEOUT_EN
  assign ctrl.m_sts_timeout = sts_to_q;
`else
  assign ctrl.m_sts_timeout = 1'b0;
`endif

  assign dma_trigger    = trig_q;
  assign dma_opcode     = dma_op_q;
  assign dma_start_addr = dma_addr_q;
  assign dma_num_bytes  = dma_bytes_q;
  assign queue_level    = level_q;
  assign idle           = (level_q == '0) && (state_q == S_IDLE) && !sts_vld_q;

endmodule

// File: doc/axi_dma_cmd_queue.md
Name: axi_dma_cmd_queue

Overview:
- Command front-end placed directly upstream of the DMA I/O engine (MM2S/S2MM pair sharing one trigger/opcode/address/length interface).
- Buffers read/write commands from a control master in a FIFO and issues them one at a time, waiting until the engine is idle.
- Returns one tagged status word per command, carrying the AXI response of the direction that ran.

Parameters:
- C_AXI_ADDR_WIDTH, 32, width of command/DMA start address.
- C_QUEUE_DEPTH, 8, command FIFO entries; power of two, 2..64.
- C_TAG_WIDTH, 4, user tag echoed from command to status.
- C_START_TIMEOUT, 64, cycles to wait for dma_busy rise (used only with optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_cmd_valid  in  1  command valid
- s_cmd_ready  out  1  command accepted when valid&ready
- s_cmd_opcode  in  1  0=read (MM2S), 1=write (S2MM)
- s_cmd_addr  in  C_AXI_ADDR_WIDTH  start address
- s_cmd_bytes  in  16  byte count
- s_cmd_tag  in  C_TAG_WIDTH  user tag
- m_sts_valid  out  1  status valid
- m_sts_ready  in  1  status consumed when valid&ready
- m_sts_tag  out  C_TAG_WIDTH  tag of finished command
- m_sts_opcode  out  1  opcode of finished command
- m_sts_resp  out  2  AXI response of finished command
- m_sts_timeout  out  1  engine never started (optional feature only, else 0)
- dma_trigger  out  1  one-cycle start pulse to engine
- dma_opcode  out  1  registered opcode to engine
- dma_start_addr  out  C_AXI_ADDR_WIDTH  registered address to engine
- dma_num_bytes  out  16  registered byte count to engine
- dma_busy  in  1  engine busy (OR of both directions)
- dma_response  in  4  [1:0] MM2S resp, [3:2] S2MM resp
- queue_level  out  clog2(C_QUEUE_DEPTH)+1  FIFO occupancy
- idle  out  1  FIFO empty, state IDLE, no pending status

Behaviour:
- Reset (sync, rst=1):
  - s_cmd_ready=0 while rst high, otherwise 1 after reset.
  - m_sts_valid=0; m_sts_* fields=0.
  - dma_trigger=0; dma_opcode/addr/bytes=0.
  - queue_level=0; idle=1.
  - FIFO flushed; FSM→IDLE.
- Reset mid-operation abandons the in-flight command: no status is produced for it. IDLE still waits for dma_busy=0 before the next issue.
- FIFO:
  - s_cmd_ready = (level != C_QUEUE_DEPTH), driven from the registered level.
  - While full, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push+pop when not full: level unchanged.
  - Pointers wrap modulo C_QUEUE_DEPTH.
  - A write becomes visible to the FSM the cycle after acceptance.
- FSM states: IDLE, WAIT_START, WAIT_DONE, REPORT.
- IDLE:
  - If FIFO non-empty and dma_busy=0: pop head.
  - If bytes==0: latch tag/opcode, resp=00, go to REPORT. No trigger is issued.
  - Otherwise: register dma_opcode/addr/bytes, assert dma_trigger next cycle (exactly one cycle), go to WAIT_START.
- WAIT_START: wait for dma_busy=1, then go to WAIT_DONE. The trigger cycle counts as cycle 0 of this state.
- WAIT_DONE: on dma_busy=0, capture the response: dma_response[1:0] if opcode=0, [3:2] if opcode=1. Go to REPORT.
- REPORT:
  - m_sts_valid=1 with stable fields until m_sts_ready.
  - On handshake: m_sts_valid=0 next cycle, go to IDLE.
  - No new command issues while a status is pending (strict one-in-flight ordering).
- dma_opcode/addr/bytes hold their values from issue until the next issue.
- Latency:
  - cmd accepted at cycle N → dma_trigger high at N+2, provided the FSM is IDLE, FIFO was empty and dma_busy=0.
  - dma_busy fall at cycle M → m_sts_valid high at M+1.
- Status order equals command order. Tags are opaque and never checked.

Optional Feature:
- Macro: AXI_DMA_CMD_QUEUE_TIMEOUT_EN.
- Defined:
  - WAIT_START counts cycles. If dma_busy is still 0 after C_START_TIMEOUT cycles, go to REPORT with m_sts_resp=2'b10 and m_sts_timeout=1.
  - If busy rises on the last counted cycle, the normal path wins.
- Undefined:
  - No counter is synthesised. WAIT_START waits indefinitely.
  - m_sts_timeout is tied to 0.

Test Plan:
- Single read, addr=0x1000, bytes=64, tag=3; engine busy 10 cycles, resp[1:0]=00 → trigger at N+2, opcode=0; status tag=3, opcode=0, resp=00 one cycle after busy falls.
- Write, bytes=128, resp[3:2]=10, resp[1:0]=11 → m_sts_resp=10 (S2MM field selected), opcode=1.
- Push 9 commands back-to-back at depth 8 with engine stalled → s_cmd_ready low after 8; 9th accepted only after the first pop; 9 statuses returned in order, tags 0..8.
- bytes=0 command → no dma_trigger pulse; status resp=00 delivered; next command still issues normally.
- Hold m_sts_ready=0 for 20 cycles with 2 queued commands → status fields stable, no second trigger until handshake; rst asserted mid-WAIT_DONE → all outputs return to reset values, level=0, idle=1.
- With AXI_DMA_CMD_QUEUE_TIMEOUT_EN, engine never raises busy → status after 64 cycles with resp=10, timeout=1; next command issues.
